dmem_result_checker: RTL
========================

# dmem_result_checker

Synthesizable read-back checker for the mips_32 data memory. After a program has run, it walks a contiguous window of data-memory words through a dedicated read port and compares each word against an expected-value ROM. It accumulates pass/fail counts and a weighted score, which are exposed for on-board self-test and for the bench. It sits beside `datapath_unit.data_mem`, on the opposite end of the memory from the preload path, and only reads.

## Interface
- `ADDR_W`, 8 — data-memory word-address width.
- `DATA_W`, 32 — data word width.
- `FIRST_ADDR`, 11 — first word address checked.
- `NUM_CHECKS`, 55 — number of consecutive words checked; `FIRST_ADDR + NUM_CHECKS - 1 < 2**ADDR_W`, enforced by an elaboration-time check.
- `clk`  in  1 — single clock; all state changes on the rising edge.
- `reset`  in  1 — asynchronous, active-low; asserted low clears all state immediately.
- `start`  in  1 — one-cycle request to begin a scan; ignored while `busy`.
- `mem_rd_en`  out  1 — read strobe to the data-memory check port.
- `mem_addr`  out  ADDR_W — word address being read.
- `mem_rd_data`  in  DATA_W — read data, valid exactly 1 cycle after `mem_rd_en`.
- `exp_idx`  out  CNT_W — index into the expected ROM (0..NUM_CHECKS-1), issued with `mem_addr`.
- `exp_data`  in  DATA_W — expected word; same 1-cycle latency as `mem_rd_data`.
- `exp_weight`  in  4 — weight of this check, in half-points; same latency.
- `busy`  out  1 — scan in progress.
- `done`  out  1 — one-cycle pulse when the scan completes.
- `pass_count`, `fail_count`  out  CNT_W — CNT_W = $clog2(NUM_CHECKS+1).
- `score_half`  out  SCORE_W — sum of `exp_weight` over passing checks; SCORE_W = CNT_W+4, so it cannot overflow.
- `first_fail_addr`  out  ADDR_W — address of the first mismatch; valid when `fail_count != 0`.
- `mismatch`  out  1 — one-cycle pulse for each failing compare.

## Operation
- FSM states: IDLE, READ, CMP, FIN.
- IDLE:
  - On `start`, clear counters, score and `first_fail_addr`.
  - Load `idx` = 0, go to READ.
- READ:
  - Drive `mem_rd_en` = 1, `mem_addr` = FIRST_ADDR + idx, `exp_idx` = idx.
  - Go to CMP.
- CMP (data valid this cycle):
  - If `mem_rd_data == exp_data`: increment `pass_count`, add `exp_weight` to `score_half`.
  - Else: increment `fail_count`, pulse `mismatch`; latch `first_fail_addr` if this is the first fail.
  - If idx == NUM_CHECKS-1, go to FIN; else increment idx and go to READ.
- FIN:
  - Pulse `done`, return to IDLE.
  - Results hold until the next `start`.
- Compare is exact over all DATA_W bits; X/Z on read data is the bench's concern.
- Address arithmetic is unsigned; no wrap occurs because of the elaboration check.

## Timing
- Reset values: `busy`, `done`, `mismatch`, `mem_rd_en` = 0; `mem_addr`, `exp_idx`, all counts, score and `first_fail_addr` = 0; state IDLE.
- `busy` rises the cycle after `start` is sampled and falls with `done`.
- Each check takes 2 cycles (READ, CMP).
- `done` is asserted 2·NUM_CHECKS + 1 cycles after `start` is sampled.
- `mem_rd_en` is never asserted on consecutive cycles.
- `start` while `busy`: ignored, no restart.
- `start` in the same cycle as `done`: ignored; a new scan requires `start` while in IDLE.
- Reset low mid-scan: immediate return to IDLE with reset values. No `done` pulse; partial results are discarded.
- NUM_CHECKS = 1: READ, CMP, FIN; `done` 3 cycles after `start`.

## Structure
- Shared package `dmem_check_pkg`: state enum (IDLE/READ/CMP/FIN), weight width constant (4), and a function computing CNT_W.
- The expected ROM is external; the bench or top-level instantiates it.
- No sub-modules. Single module with an FSM, one index counter and one accumulator block.

## Test plan
- Preload ram[11] = 6a314303, expected[0] = 6a314303, weight 2, NUM_CHECKS = 1, pulse `start` → `done` at cycle 3, `pass_count` = 1, `fail_count` = 0, `score_half` = 2.
- 55 words all matching with the standard weights (45×2, 10×5) → `pass_count` = 55, `score_half` = 140, `done` at cycle 111, `mismatch` never pulses.
- Corrupt ram[16] (fe400001 vs fe400000) and ram[40] → `fail_count` = 2, `first_fail_addr` = 16, `mismatch` pulses in the CMP cycles for idx 5 and idx 29.
- Pulse `start` again at cycle 20 of a scan → ignored; `done` still at cycle 111 and counts unchanged.
- Drive `reset` low at cycle 30, release, then `start` → all outputs zero during reset; the second scan produces full, correct counts.
- Pulse `start` in the cycle `done` is high → no new scan; `busy` stays 0.

Source files
------------

// File: rtl/dmem_check_pkg.sv
// Shared types and constants for the data-memory read-back checker.
package dmem_check_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      CMP,
      FIN
   } check_state_t;

   localparam int WEIGHT_W = 4;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/dmem_result_checker.sv
// Walks a window of data-memory words, compares each against an external
// expected ROM and accumulates pass/fail counts plus a weighted score.
module dmem_result_checker
   import dmem_check_pkg::*;
#(
   parameter  int ADDR_W     = 8,
   parameter  int DATA_W     = 32,
   parameter  int FIRST_ADDR = 11,
   parameter  int NUM_CHECKS = 55,
   localparam int CNT_W      = cnt_width(NUM_CHECKS),
   localparam int SCORE_W    = CNT_W + WEIGHT_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic                mem_rd_en,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_rd_data,
   output logic [CNT_W-1:0]    exp_idx,
   input  logic [DATA_W-1:0]   exp_data,
   input  logic [WEIGHT_W-1:0] exp_weight,
   output logic                busy,
   output logic                done,
   output logic [CNT_W-1:0]    pass_count,
   output logic [CNT_W-1:0]    fail_count,
   output logic [SCORE_W-1:0]  score_half,
   output logic [ADDR_W-1:0]   first_fail_addr,
   output logic                mismatch
);

   generate
      if (NUM_CHECKS < 1 || (FIRST_ADDR + NUM_CHECKS - 1) >= (1 << ADDR_W)) begin : g_bad_cfg
         $error("dmem_result_checker: check window exceeds the data-memory address range");
      end
   endgenerate

   check_state_t     state_reg;
   logic [CNT_W-1:0] idx_reg;
   logic             word_differs;

   assign word_differs = (mem_rd_data != exp_data);
   // Flagged in the compare cycle itself, while the read data is on the bus.
   assign mismatch     = (state_reg == CMP) && word_differs;
   assign exp_idx      = idx_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg       <= IDLE;
         idx_reg         <= '0;
         mem_rd_en       <= 1'b0;
         mem_addr        <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass_count      <= '0;
         fail_count      <= '0;
         score_half      <= '0;
         first_fail_addr <= '0;
      end else begin
         done      <= 1'b0;
         mem_rd_en <= 1'b0;
         case (state_reg)
            IDLE: begin
               // A start coinciding with the completion pulse does not re-arm.
               if (start && !done) begin
                  pass_count      <= '0;
                  fail_count      <= '0;
                  score_half      <= '0;
                  first_fail_addr <= '0;
                  idx_reg         <= '0;
                  mem_addr        <= ADDR_W'(FIRST_ADDR);
                  mem_rd_en       <= 1'b1;
                  busy            <= 1'b1;
                  state_reg       <= READ;
               end
            end
            READ: begin
               state_reg <= CMP;
            end
            CMP: begin
               if (!word_differs) begin
                  pass_count <= pass_count + 1'b1;
                  score_half <= score_half + SCORE_W'(exp_weight);
               end else begin
                  fail_count <= fail_count + 1'b1;
                  if (fail_count == '0) begin
                     first_fail_addr <= mem_addr;
                  end
               end
               if (idx_reg == CNT_W'(NUM_CHECKS - 1)) begin
                  state_reg <= FIN;
               end else begin
                  idx_reg   <= idx_reg + 1'b1;
                  mem_addr  <= mem_addr + 1'b1;
                  mem_rd_en <= 1'b1;
                  state_reg <= READ;
               end
            end
            FIN: begin
               done      <= 1'b1;
               busy      <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule
